// File: rtl/seg_display_sched.sv
// rtl/seg_display_sched.sv - round-robin time-sharing of a 4-digit BCD display
module seg_display_sched #(
    parameter int N_REQ       = 3,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [14*N_REQ-1:0]  req_bin,
    input  logic [3*N_REQ-1:0]   req_dot,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic [15:0]          disp_data,
    output logic [2:0]           disp_dot,
    output logic [1:0]           disp_src,
    output logic                 ovf
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONV     = 2'd1,
        LOAD_OUT = 2'd2,
        SHOW     = 2'd3
    } state_t;

    state_t         state;
    logic [1:0]     last;
    logic [13:0]    bin_sr;
    logic [15:0]    bcd;
    logic [2:0]     dot_cap;
    logic [1:0]     src_cap;
    logic           ovf_pend;
    logic [3:0]     step;
    logic [HW-1:0]  hold;

    logic           found;
    logic [1:0]     win;
    logic [13:0]    win_bin;
    logic [2:0]     win_dot;
    logic [15:0]    bcd_adj;

    // Round-robin search: first requester set, starting just after the last winner
    always_comb begin
        int          idx;
        logic [N_REQ-1:0] sh;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        sh    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            sh  = req >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
    end

    // Winner's value and dot position, selected by shifting the packed request buses
    always_comb begin
        win_bin = 14'(req_bin >> (14 * win));
        win_dot = 3'(req_dot >> (3 * win));
    end

    // Shift-add-3 correction: every BCD nibble of 5 or more gets +3 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Scheduler FSM: arbitrate, convert, load display, hold, with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 2'(N_REQ - 1);
            gnt       <= '0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            disp_data <= 16'hFFFF;
            disp_dot  <= 3'd7;
            disp_src  <= 2'd0;
            bin_sr    <= '0;
            bcd       <= '0;
            dot_cap   <= 3'd7;
            src_cap   <= '0;
            ovf_pend  <= 1'b0;
            step      <= '0;
            hold      <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= N_REQ'(1) << win;
                        last     <= win;
                        src_cap  <= win;
                        bin_sr   <= win_bin;
                        dot_cap  <= win_dot;
                        ovf_pend <= (win_bin > 14'd9999);
                        bcd      <= '0;
                        step     <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd    <= {bcd_adj[14:0], bin_sr[13]};
                    bin_sr <= {bin_sr[12:0], 1'b0};
                    step   <= step + 4'd1;
                    if (step == 4'd13) begin
                        state <= LOAD_OUT;
                    end
                end
                LOAD_OUT: begin
                    disp_data <= ovf_pend ? 16'hFFFF : bcd;
                    disp_dot  <= dot_cap;
                    disp_src  <= src_cap;
                    ovf       <= ovf_pend;
                    hold      <= '0;
                    state     <= SHOW;
                end
                SHOW: begin
                    hold <= hold + 1'b1;
                    if (hold == HW'(HOLD_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_sched.sv
// tb/tb_seg_display_sched.sv - directed self-checking bench for seg_display_sched
module tb_seg_display_sched;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [41:0] req_bin;
    logic [8:0]  req_dot;
    logic [2:0]  gnt;
    logic        busy;
    logic [15:0] disp_data;
    logic [2:0]  disp_dot;
    logic [1:0]  disp_src;
    logic        ovf;

    int n_cmp;
    int n_bad;
    int cyc;

    seg_display_sched #(.N_REQ(3), .HOLD_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_bin   (req_bin),
        .req_dot   (req_dot),
        .gnt       (gnt),
        .busy      (busy),
        .disp_data (disp_data),
        .disp_dot  (disp_dot),
        .disp_src  (disp_src),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt != 3'b000) break;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    int t_prev;
    int t_now;
    logic [2:0] exp_g [4];
    logic [13:0] vals [3];
    logic       saw_gnt;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        rst     = 1'b1;
        req     = 3'b000;
        req_bin = '0;
        req_dot = {3'd7, 3'd7, 3'd7};

        // 1: reset state, held with no requests
        tick(2);
        check("rst_data", 32'(disp_data), 32'hFFFF);
        check("rst_dot",  32'(disp_dot),  32'd7);
        check("rst_gnt",  32'(gnt),       32'd0);
        check("rst_busy", 32'(busy),      32'd0);
        check("rst_ovf",  32'(ovf),       32'd0);
        check("rst_src",  32'(disp_src),  32'd0);
        rst = 1'b0;
        tick(3);
        check("idle_data", 32'(disp_data), 32'hFFFF);
        check("idle_busy", 32'(busy),      32'd0);

        // 2: single conversion 1234, dot 2
        req_bin[13:0] = 14'd1234;
        req_dot[2:0]  = 3'd2;
        req = 3'b001;
        wait_gnt(10);
        check("t2_gnt",  32'(gnt),  32'b001);
        check("t2_busy", 32'(busy), 32'd1);
        req = 3'b000;
        tick(1);
        check("t2_gnt_pulse", 32'(gnt), 32'd0);
        tick(14);
        check("t2_data", 32'(disp_data), 32'h1234);
        check("t2_dot",  32'(disp_dot),  32'd2);
        check("t2_src",  32'(disp_src),  32'd0);
        tick(3);
        check("t2_busy_e18", 32'(busy), 32'd1);
        tick(1);
        check("t2_busy_e19", 32'(busy), 32'd0);

        // 3: all three requesting, round-robin order and spacing
        pulse_reset();
        req_bin = {14'd3, 14'd2, 14'd1};
        req_dot = {3'd0, 3'd1, 3'd3};
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        vals[0] = 14'd1; vals[1] = 14'd2; vals[2] = 14'd3;
        req = 3'b111;
        t_prev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_gnt(40);
            t_now = cyc;
            check($sformatf("t3_gnt%0d", g), 32'(gnt), 32'(exp_g[g]));
            if (g > 0) check($sformatf("t3_gap%0d", g), 32'(t_now - t_prev), 32'd20);
            t_prev = t_now;
            if (g == 3) req = 3'b000;
            tick(15);
            check($sformatf("t3_data%0d", g), 32'(disp_data), 32'({12'h000, 4'(vals[g % 3])}));
            check($sformatf("t3_src%0d", g),  32'(disp_src),  32'(g % 3));
        end
        wait_idle("t3_idle", 20);

        // 4: overflow boundary and the 9999 / 0 edges
        req_bin[13:0] = 14'd10000;
        req = 3'b001;
        wait_gnt(10);
        req = 3'b000;
        tick(15);
        check("t4_ovf_data", 32'(disp_data), 32'hFFFF);
        check("t4_ovf_flag", 32'(ovf),       32'd1);
        wait_idle("t4_idle_a", 20);
        req_bin[13:0] = 14'd9999;
        req = 3'b001;
        wait_gnt(10);
        req = 3'b000;
        tick(15);
        check("t4_9999_data", 32'(disp_data), 32'h9999);
        check("t4_9999_flag", 32'(ovf),       32'd0);
        wait_idle("t4_idle_b", 20);
        req_bin[13:0] = 14'd0;
        req = 3'b001;
        wait_gnt(10);
        req = 3'b000;
        tick(15);
        check("t4_zero_data", 32'(disp_data), 32'h0000);
        wait_idle("t4_idle_c", 20);

        // 5: reset in the middle of a conversion
        req_bin[27:14] = 14'd42;
        req = 3'b010;
        wait_gnt(10);
        check("t5_gnt", 32'(gnt), 32'b010);
        req = 3'b000;
        tick(6);
        rst = 1'b1;
        tick(1);
        check("t5_rst_data", 32'(disp_data), 32'hFFFF);
        check("t5_rst_dot",  32'(disp_dot),  32'd7);
        check("t5_rst_gnt",  32'(gnt),       32'd0);
        check("t5_rst_busy", 32'(busy),      32'd0);
        rst = 1'b0;
        req = 3'b011;
        wait_gnt(10);
        check("t5_first_gnt", 32'(gnt), 32'b001);
        req = 3'b000;
        wait_idle("t5_idle", 30);

        // 6: requester 2 withdraws before arbitration, only requester 1 is served
        req = 3'b010;
        wait_gnt(10);
        check("t6_gnt_a", 32'(gnt), 32'b010);
        req = 3'b110;
        tick(18);
        req = 3'b010;
        wait_gnt(10);
        check("t6_gnt_b", 32'(gnt), 32'b010);
        req = 3'b000;
        saw_gnt = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (gnt != 3'b000) saw_gnt = 1'b1;
        end
        check("t6_no_more_gnt", 32'(saw_gnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
